// File: rtl/la_defs.sv
// Shared definitions for the sample FIFO serializer: serializer state encoding and widths.
package la_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int OVF_CNT_W      = 16;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a registered 1-cycle read.
module sample_ram #(
    parameter int WORD_W     = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [WORD_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [WORD_W-1:0]     rd_data_o
);

    logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [WORD_W-1:0] rd_data_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_fifo_serializer.sv
// Sample word FIFO feeding a little-endian byte serializer (valid/ready) toward the UART TX.
// Optional saturating drop counter enabled by defining SAMPLE_FIFO_OVERFLOW_CNT_EN.
module sample_fifo_serializer
    import la_defs::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int WORD_W     = 32
) (
    input  logic                  i_clk,
    input  logic                  _mrst,
    input  logic                  i_save,
    input  logic [WORD_W-1:0]     i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [7:0]            o_byte,
    output logic                  o_byte_valid,
    input  logic                  i_byte_ready,
    output logic [OVF_CNT_W-1:0]  o_overflow_cnt
);

    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [1:0]            LAST_IDX   = 2'(BYTES_PER_WORD - 1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  wr_en;
    logic                  pop;
    logic [WORD_W-1:0]     ram_rd_data;

    state_e                state_q;
    logic [WORD_W-1:0]     shreg_q;
    logic [7:0]            byte_q;
    logic                  valid_q;
    logic [1:0]            idx_q;

    // Both gates use the registered flags: a pop in the same cycle never frees room for a write.
    assign wr_en = i_save & ~full_q;
    assign pop   = (state_q == ST_IDLE) & ~empty_q;

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
            full_q  <= (level_d == FULL_LEVEL);
            empty_q <= (level_d == '0);
        end
    end

    sample_ram #(
        .WORD_W     (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i     (i_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_data),
        .rd_en_i   (pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    // The shift register always holds the current byte in its low 8 bits.
    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    shreg_q <= ram_rd_data;
                    byte_q  <= ram_rd_data[7:0];
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (valid_q && i_byte_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            shreg_q <= shreg_q >> 8;
                            byte_q  <= shreg_q[15:8];
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_full       = full_q;
    assign o_empty      = empty_q;
    assign o_level      = level_q;
    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;

`ifdef SAMPLE_FIFO_OVERFLOW_CNT_EN
    localparam logic [OVF_CNT_W-1:0] OVF_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            ovf_cnt_q <= '0;
        end else if (i_save && full_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_ONE;
        end
    end

    assign o_overflow_cnt = ovf_cnt_q;
`else
    assign o_overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_fifo_serializer.sv
// Bench for sample_fifo_serializer: queue-based reference model checked every cycle plus directed literals.
module tb_sample_fifo_serializer;

    localparam int DL    = 2;
    localparam int DEPTH = 4;
`ifdef SAMPLE_FIFO_OVERFLOW_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        _mrst = 1'b0;
    logic        i_save = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_byte_ready = 1'b0;
    logic        o_full;
    logic        o_empty;
    logic [DL:0] o_level;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic [15:0] o_overflow_cnt;

    always #5 i_clk = ~i_clk;

    sample_fifo_serializer #(
        .DEPTH_LOG2 (DL),
        .WORD_W     (32)
    ) dut (
        .i_clk          (i_clk),
        ._mrst          (_mrst),
        .i_save         (i_save),
        .i_data         (i_data),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_level        (o_level),
        .o_byte         (o_byte),
        .o_byte_valid   (o_byte_valid),
        .i_byte_ready   (i_byte_ready),
        .o_overflow_cnt (o_overflow_cnt)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: stored words in a queue, plus the one word being sent byte by byte.
    logic [31:0] m_q[$];
    logic [31:0] m_word = '0;
    bit          m_busy = 0, m_wait = 0, m_valid = 0;
    int          m_idx = 0, m_ovf = 0;
    bit          m_acc, m_fullb, m_wr, m_pop;
    logic [7:0]  m_exp_byte;

    initial begin
        forever begin
            @(negedge i_clk);
            if (!_mrst) begin
                m_q.delete();
                m_busy = 0; m_wait = 0; m_valid = 0; m_idx = 0; m_ovf = 0;
                check("rst_byte", {24'h0, o_byte}, 32'h0);
            end
            check("level", {29'h0, o_level}, 32'(m_q.size()));
            check("empty", {31'h0, o_empty}, {31'h0, m_q.size() == 0});
            check("full", {31'h0, o_full}, {31'h0, m_q.size() == DEPTH});
            check("valid", {31'h0, o_byte_valid}, {31'h0, m_valid});
            m_exp_byte = m_word[8*m_idx +: 8];
            if (m_valid) check("byte", {24'h0, o_byte}, {24'h0, m_exp_byte});
            check("ovf", {16'h0, o_overflow_cnt}, 32'(m_ovf));
            if (_mrst) begin
                m_acc   = m_valid && i_byte_ready;
                m_fullb = (m_q.size() == DEPTH);
                m_wr    = i_save && !m_fullb;
                m_pop   = !m_busy && (m_q.size() > 0);
                if (i_save && m_fullb && OVF_EN && m_ovf < 65535) m_ovf++;
                if (m_pop) begin
                    m_word = m_q.pop_front();
                    m_busy = 1; m_wait = 1; m_idx = 0; m_valid = 0;
                end else if (m_wait) begin
                    m_wait = 0; m_valid = 1;
                end else if (m_acc) begin
                    if (m_idx == 3) begin
                        $display("word %08h sent", m_word);
                        m_busy = 0; m_valid = 0;
                    end else begin
                        m_idx++;
                    end
                end
                if (m_wr) m_q.push_back(i_data);
            end
        end
    end

    logic [7:0] got[$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic save(input logic [31:0] d);
        i_save = 1'b1;
        i_data = d;
        tick();
        i_save = 1'b0;
    endtask

    task automatic do_reset();
        _mrst = 1'b0;
        tick();
        tick();
        _mrst = 1'b1;
    endtask

    // Gathers n accepted bytes into got; ends on the negedge before the last handshake edge.
    task automatic collect(input int n);
        int budget = 300;
        got.delete();
        while (got.size() < n && budget > 0) begin
            @(negedge i_clk);
            if (o_byte_valid && i_byte_ready) got.push_back(o_byte);
            budget--;
        end
        if (got.size() < n) check("collect_timeout", 32'(got.size()), 32'(n));
    endtask

    task automatic wait_handshakes(input int n);
        int seen = 0;
        int budget = 100;
        while (seen < n && budget > 0) begin
            @(negedge i_clk);
            if (o_byte_valid && i_byte_ready) seen++;
            budget--;
        end
        if (seen < n) check("handshake_timeout", 32'(seen), 32'(n));
    endtask

    initial begin
        int t, t_ne, t_v, t_r0, t_r1;
        bit prev_v;
        logic [31:0] seq;

        // Test 1: single word, byte order, latency, empty afterwards
        _mrst = 1'b0;
        repeat (3) tick();
        _mrst = 1'b1;
        check("reset_empty", {31'h0, o_empty}, 32'h1);
        check("reset_valid", {31'h0, o_byte_valid}, 32'h0);
        i_byte_ready = 1'b1;
        save(32'h00123456);
        got.delete();
        t = 0; t_ne = -1; t_v = -1;
        while (got.size() < 4 && t < 40) begin
            @(negedge i_clk);
            if (!o_empty && t_ne < 0) t_ne = t;
            if (o_byte_valid && t_v < 0) t_v = t;
            if (o_byte_valid && i_byte_ready) got.push_back(o_byte);
            t++;
        end
        check("t1_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("t1_b0", {24'h0, got[0]}, 32'h56);
            check("t1_b1", {24'h0, got[1]}, 32'h34);
            check("t1_b2", {24'h0, got[2]}, 32'h12);
            check("t1_b3", {24'h0, got[3]}, 32'h00);
        end
        check("t1_latency", 32'(t_v - t_ne), 32'd2);
        tick();
        tick();
        check("t1_empty_after", {31'h0, o_empty}, 32'h1);

        // Back-to-back words: write+pop at level 1 keeps level 1; word period 6 cycles
        save(32'hCAFEF00D);
        save(32'h12345678);
        check("wp_level_hold", {29'h0, o_level}, 32'd1);
        got.delete();
        t = 0; t_r0 = -1; t_r1 = -1; prev_v = 0;
        while (got.size() < 8 && t < 60) begin
            @(negedge i_clk);
            if (o_byte_valid && !prev_v) begin
                if (t_r0 < 0) t_r0 = t; else if (t_r1 < 0) t_r1 = t;
            end
            prev_v = o_byte_valid;
            if (o_byte_valid && i_byte_ready) got.push_back(o_byte);
            t++;
        end
        check("wp_period", 32'(t_r1 - t_r0), 32'd6);
        if (got.size() == 8) check("wp_b4", {24'h0, got[4]}, 32'h78);
        tick();

        // Test 2: stall at idx=1 for 10 cycles, then release
        save(32'h00123456);
        wait_handshakes(1);
        tick();
        i_byte_ready = 1'b0;
        repeat (10) begin
            @(negedge i_clk);
            check("t2_hold_byte", {24'h0, o_byte}, 32'h34);
            check("t2_hold_valid", {31'h0, o_byte_valid}, 32'h1);
        end
        tick();
        i_byte_ready = 1'b1;
        collect(3);
        if (got.size() == 3) begin
            check("t2_resume0", {24'h0, got[0]}, 32'h34);
            check("t2_resume2", {24'h0, got[2]}, 32'h00);
        end
        tick();

        // Test 3: fill depth-4 FIFO with the serializer stalled; sixth save is dropped
        do_reset();
        i_byte_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_save = 1'b1;
            i_data = 32'hA0B0C0D0 + 32'(k);
            tick();
        end
        i_save = 1'b0;
        check("t3_full", {31'h0, o_full}, 32'h1);
        check("t3_level", {29'h0, o_level}, 32'd4);
        check("t3_ovf", {16'h0, o_overflow_cnt}, OVF_EN ? 32'd1 : 32'd0);
        check("t3_byte0", {24'h0, o_byte}, 32'hD0);
        i_byte_ready = 1'b1;
        collect(20);
        if (got.size() == 20) check("t3_last_word_b0", {24'h0, got[16]}, 32'hD4);
        repeat (8) tick();
        check("t3_no_sixth", {31'h0, o_byte_valid}, 32'h0);
        check("t3_empty", {31'h0, o_empty}, 32'h1);

        // Test 4: random save/ready traffic over many depths, model checks the stream
        do_reset();
        seq = 32'h01000000;
        for (int c = 0; c < 240; c++) begin
            i_save = ($urandom_range(0, 3) != 0);
            i_data = seq;
            seq = seq + 32'h00010203;
            i_byte_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        i_save = 1'b0;
        i_byte_ready = 1'b1;
        repeat (60) tick();
        check("t4_drained", {31'h0, o_empty}, 32'h1);
        check("t4_idle", {31'h0, o_byte_valid}, 32'h0);

        // Test 5: reset pulse mid-word at idx=2 with one word still stored
        do_reset();
        i_byte_ready = 1'b1;
        save(32'h44332211);
        save(32'h88776655);
        wait_handshakes(2);
        tick();
        i_byte_ready = 1'b0;
        check("t5_idx2_byte", {24'h0, o_byte}, 32'h33);
        check("t5_level_pre", {29'h0, o_level}, 32'd1);
        _mrst = 1'b0;
        #1;
        check("t5_valid_drop", {31'h0, o_byte_valid}, 32'h0);
        check("t5_level", {29'h0, o_level}, 32'd0);
        check("t5_empty", {31'h0, o_empty}, 32'h1);
        tick();
        tick();
        _mrst = 1'b1;
        i_byte_ready = 1'b1;
        save(32'hDDCCBBAA);
        collect(4);
        if (got.size() == 4) begin
            check("t5_new_b0", {24'h0, got[0]}, 32'hAA);
            check("t5_new_b3", {24'h0, got[3]}, 32'hDD);
        end
        tick();

        // Test 6: long overflow burst
        do_reset();
        i_byte_ready = 1'b0;
        i_data = 32'h5A5A5A5A;
        i_save = 1'b1;
`ifdef SAMPLE_FIFO_OVERFLOW_CNT_EN
        repeat (70010) tick();
        i_save = 1'b0;
        check("t6_ovf_sat", {16'h0, o_overflow_cnt}, 32'h0000FFFF);
`else
        repeat (30) tick();
        i_save = 1'b0;
        check("t6_ovf_off", {16'h0, o_overflow_cnt}, 32'h0);
`endif
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
